// File: rtl/lsq_port_arbiter.sv
// lsq_port_arbiter: round-robin sharing of one LSQ port among NUM_REQ OUs, with in-order load tag routing
module lsq_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_REQ-1:0] req_pending,
  input  logic [NUM_REQ-1:0] req_new_request,
  input  logic [NUM_REQ-1:0][XLEN-1:0] req_addr,
  input  logic [NUM_REQ-1:0][XLEN-1:0] req_data,
  input  logic [NUM_REQ-1:0][2:0] req_fn3,
  input  logic [NUM_REQ-1:0] req_load,
  input  logic [NUM_REQ-1:0] req_store,
  output logic [NUM_REQ-1:0] req_lsq_full,
  output logic [XLEN-1:0] req_load_data,
  output logic [NUM_REQ-1:0] req_load_complete,
  output logic [XLEN-1:0] addr,
  output logic [XLEN-1:0] data,
  output logic [2:0] fn3,
  output logic load,
  output logic store,
  output logic new_request,
  input  logic lsq_full,
  input  logic [XLEN-1:0] load_data,
  input  logic load_complete,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic err_orphan_complete
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(MAX_OUTSTANDING);
  localparam int CW = TW + 1;
  logic [PW-1:0] ptr, g;
  logic gv, tag_full, empty, push, pop;
  logic [NUM_REQ-1:0] gh;
  logic [PW-1:0] tags [MAX_OUTSTANDING];
  logic [TW-1:0] wp, rp;
  logic [CW-1:0] count;
  // downward scan so the candidate closest to ptr wins
  always_comb begin
    gv = 1'b0;
    g = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_pending[PW'((int'(ptr) + k) % NUM_REQ)]) begin
        gv = 1'b1;
        g = PW'((int'(ptr) + k) % NUM_REQ);
      end
  end
  assign gh = gv ? NUM_REQ'(1) << g : '0;
  assign tag_full = count == CW'(MAX_OUTSTANDING);
  assign empty = count == '0;
  assign new_request = gv && req_new_request[g] && !lsq_full && !tag_full && !rst;
  assign push = new_request && req_load[g];
  assign pop = load_complete && !empty && !rst;
  assign req_lsq_full = rst ? '1 : ~gh | {NUM_REQ{lsq_full || tag_full}};
  assign addr = gv ? req_addr[g] : '0;
  assign data = gv ? req_data[g] : '0;
  assign fn3 = gv ? req_fn3[g] : '0;
  assign load = gv && !rst && req_load[g];
  assign store = gv && !rst && req_store[g];
  assign req_load_complete = pop ? NUM_REQ'(1) << tags[rp] : '0;
  assign req_load_data = load_data;
  assign outstanding = count;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      err_orphan_complete <= 1'b0;
    end else begin
      if (new_request) ptr <= (g == PW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      err_orphan_complete <= err_orphan_complete | (load_complete && empty);
    end
  end
  always_ff @(posedge clk)
    if (push) tags[wp] <= g;
endmodule

// File: tb/tb_lsq_port_arbiter.sv
// tb_lsq_port_arbiter: directed and random checks of the LSQ port arbiter against a queue-based model
module tb_lsq_port_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req_pending = '0, req_new_request = '0, req_load = '0, req_store = '0;
  logic [3:0][31:0] req_addr = '0, req_data = '0;
  logic [3:0][2:0] req_fn3 = '0;
  logic [3:0] req_lsq_full, req_load_complete;
  logic [31:0] req_load_data, addr, data, load_data = '0;
  logic [2:0] fn3, outstanding;
  logic load, store, new_request, lsq_full = 1'b0, load_complete = 1'b0, err_orphan_complete;
  int passed = 0, total = 0;
  int ptr_m = 0;
  bit err_m = 1'b0;
  int q[$];

  lsq_port_arbiter #(.NUM_REQ(4), .MAX_OUTSTANDING(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .req_pending(req_pending), .req_new_request(req_new_request),
    .req_addr(req_addr), .req_data(req_data), .req_fn3(req_fn3), .req_load(req_load),
    .req_store(req_store), .req_lsq_full(req_lsq_full), .req_load_data(req_load_data),
    .req_load_complete(req_load_complete), .addr(addr), .data(data), .fn3(fn3),
    .load(load), .store(store), .new_request(new_request), .lsq_full(lsq_full),
    .load_data(load_data), .load_complete(load_complete), .outstanding(outstanding),
    .err_orphan_complete(err_orphan_complete));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [3:0] pend, input logic [3:0] ld, input logic lf, input logic lc);
    req_pending = pend;
    req_new_request = pend;
    req_load = ld;
    req_store = ~ld;
    lsq_full = lf;
    load_complete = lc;
    load_data = $urandom;
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = $urandom;
      req_data[i] = $urandom;
      req_fn3[i] = 3'($urandom);
    end
  endtask

  // one cycle: drive, predict from the grant rules and tag queue, compare, then advance the model
  task automatic cyc(input logic [3:0] pend, input logic [3:0] ld, input logic lf, input logic lc);
    int eg;
    bit tf, enr;
    logic [3:0] ef;
    drive(pend, ld, lf, lc);
    #2;
    eg = -1;
    for (int k = 0; k < 4; k++)
      if (eg < 0 && pend[(ptr_m + k) % 4]) eg = (ptr_m + k) % 4;
    tf = q.size() == 4;
    for (int i = 0; i < 4; i++) ef[i] = (i != eg) || lf || tf;
    enr = eg >= 0 && !lf && !tf;
    chk("new_request", 64'(new_request), 64'(enr));
    chk("req_lsq_full", 64'(req_lsq_full), 64'(ef));
    chk("addr", 64'(addr), eg >= 0 ? 64'(req_addr[eg]) : 64'd0);
    chk("data", 64'(data), eg >= 0 ? 64'(req_data[eg]) : 64'd0);
    chk("fn3", 64'(fn3), eg >= 0 ? 64'(req_fn3[eg]) : 64'd0);
    chk("load", 64'(load), eg >= 0 ? 64'(ld[eg]) : 64'd0);
    chk("store", 64'(store), eg >= 0 ? 64'(!ld[eg]) : 64'd0);
    chk("req_load_complete", 64'(req_load_complete), (lc && q.size() > 0) ? (64'd1 << q[0]) : 64'd0);
    if (lc) chk("req_load_data", 64'(req_load_data), 64'(load_data));
    chk("outstanding", 64'(outstanding), 64'(q.size()));
    chk("err_orphan", 64'(err_orphan_complete), 64'(err_m));
    @(posedge clk);
    if (lc) begin
      if (q.size() > 0) void'(q.pop_front());
      else err_m = 1'b1;
    end
    if (enr) begin
      ptr_m = (eg + 1) % 4;
      if (ld[eg]) q.push_back(eg);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'($urandom), 4'($urandom), 1'b0, 1'b1);
    #2;
    chk("rst_new_request", 64'(new_request), 64'd0);
    chk("rst_load", 64'(load), 64'd0);
    chk("rst_store", 64'(store), 64'd0);
    chk("rst_req_lsq_full", 64'(req_lsq_full), 64'hf);
    chk("rst_req_load_complete", 64'(req_load_complete), 64'd0);
    @(posedge clk);
    q.delete();
    ptr_m = 0;
    err_m = 1'b0;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    cyc(4'b0100, 4'b1111, 0, 0);
    cyc(4'b1111, 4'b0000, 0, 0);
    cyc(4'b0000, 4'b0000, 0, 1);
    do_reset();
    repeat (8) cyc(4'b1111, 4'b0000, 0, 0);
    cyc(4'b1000, 4'b1111, 0, 0);
    cyc(4'b0010, 4'b1111, 0, 0);
    cyc(4'b0010, 4'b1111, 0, 0);
    repeat (3) cyc(4'b0000, 4'b0000, 0, 1);
    repeat (4) cyc(4'b0001, 4'b1111, 0, 0);
    cyc(4'b0001, 4'b1111, 0, 1);
    cyc(4'b0001, 4'b1111, 0, 0);
    cyc(4'b1111, 4'b0000, 0, 0);
    repeat (4) cyc(4'b0000, 4'b0000, 0, 1);
    do_reset();
    repeat (2) cyc(4'b0001, 4'b0000, 1, 0);
    cyc(4'b1111, 4'b0000, 1, 0);
    repeat (2) cyc(4'b1111, 4'b0000, 0, 0);
    cyc(4'b0000, 4'b0000, 0, 1);
    cyc(4'b0000, 4'b0000, 0, 0);
    cyc(4'b1111, 4'b1111, 0, 0);
    cyc(4'b0000, 4'b0000, 0, 1);
    do_reset();
    cyc(4'b0000, 4'b0000, 0, 0);
    cyc(4'b0010, 4'b0000, 0, 0);
    for (int n = 0; n < 600; n++) begin
      if (n % 200 == 199) do_reset();
      cyc(4'($urandom), 4'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
